multiplicador_seq: RTL and testbench

- Iterative 16×16 multiplier producing the 32-bit product in two 16-bit halves, `mulH` (bits 31:16) and `mulL` (bits 15:0).
- These are the values the ALU returns for `codop` 13 and 14.
- Sits beside the ALU in the datapath. The control unit pulses `start` with the two operands, stalls on `busy`, and the product halves stay registered until the next multiply completes.
- Supports unsigned and two's-complement signed operation, selected per operation.

---
 rtl/multiplicador_seq.sv | 110 +++++++++++
 tb/tb_multiplicador_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq.sv
// Iterative LARGURA x LARGURA shift-add multiplier, one multiplier bit per clock.
// Signed mode weights the multiplier MSB negatively, so the final partial product is subtracted.
module multiplicador_seq #(
  parameter int LARGURA = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sinal,
  input  logic [LARGURA-1:0] operando1,
  input  logic [LARGURA-1:0] operando2,
  output logic               busy,
  output logic               done,
  output logic [LARGURA-1:0] mulH,
  output logic [LARGURA-1:0] mulL
);

  localparam int CW = $clog2(LARGURA);
  localparam logic [CW-1:0] ULTIMA = CW'(LARGURA - 1);

  typedef enum logic {
    OCIOSO,
    CALCULA
  } estado_t;

  estado_t                r_estado;
  estado_t                w_prox_estado;
  logic [CW-1:0]          r_cont;
  logic [2*LARGURA-1:0]   r_mcand;
  logic [LARGURA-1:0]     r_mplier;
  logic [2*LARGURA-1:0]   r_acc;
  logic                   r_sinal;
  logic                   r_done;
  logic [LARGURA-1:0]     r_mulH;
  logic [LARGURA-1:0]     r_mulL;

  logic                   w_ultima;
  logic                   w_ext;
  logic [2*LARGURA-1:0]   w_parcial;
  logic [2*LARGURA-1:0]   w_acc_prox;

  assign busy = (r_estado == CALCULA);
  assign done = r_done;
  assign mulH = r_mulH;
  assign mulL = r_mulL;

  always_comb begin
    w_prox_estado = r_estado;
    w_ultima      = (r_estado == CALCULA) && (r_cont == ULTIMA);
    w_ext         = sinal & operando1[LARGURA-1];
    w_parcial     = r_mplier[0] ? r_mcand : '0;
    // Last iteration carries the multiplier sign bit: weight -2^(LARGURA-1) when signed.
    if (w_ultima && r_sinal) begin
      w_acc_prox = r_acc - w_parcial;
    end else begin
      w_acc_prox = r_acc + w_parcial;
    end
    case (r_estado)
      OCIOSO:  if (start)    w_prox_estado = CALCULA;
      CALCULA: if (w_ultima) w_prox_estado = OCIOSO;
      default: w_prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cont   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_sinal  <= 1'b0;
      r_done   <= 1'b0;
      r_mulH   <= '0;
      r_mulL   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (start) begin
            r_mcand  <= {{LARGURA{w_ext}}, operando1};
            r_mplier <= operando2;
            r_sinal  <= sinal;
            r_acc    <= '0;
            r_cont   <= '0;
          end
        end
        CALCULA: begin
          r_acc    <= w_acc_prox;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cont   <= r_cont + CW'(1);
          if (w_ultima) begin
            {r_mulH, r_mulL} <= w_acc_prox;
            r_done           <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Bench for multiplicador_seq: vector table, corner sequences and random operands,
// with a queue of expected products popped whenever done pulses.
module tb_multiplicador_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sinal;
  logic [W-1:0] operando1;
  logic [W-1:0] operando2;
  logic         busy;
  logic         done;
  logic [W-1:0] mulH;
  logic [W-1:0] mulL;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [2*W-1:0] sb[$];

  multiplicador_seq #(.LARGURA(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sinal     (sinal),
    .operando1 (operando1),
    .operando2 (operando2),
    .busy      (busy),
    .done      (done),
    .mulH      (mulH),
    .mulL      (mulL)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nome;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp_h;
    logic [W-1:0] exp_l;
  } vetor_t;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", nome, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb_;
    logic signed [63:0] p;
    sa  = s ? 64'($signed(a)) : 64'(a);
    sb_ = s ? 64'($signed(b)) : 64'(b);
    p   = sa * sb_;
    return p[31:0];
  endfunction

  // Launch from a point away from the clock edge; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [31:0] exp);
    operando1 = a;
    operando2 = b;
    sinal     = s;
    start     = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_low_after_start", {31'd0, done}, 32'd0);
  endtask

  // Waits for done after a launch; optionally pulses start with junk operands mid-operation.
  task automatic wait_done(input string nome, input int pulse_at);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) nbusy++;
      if (pulse_at != 0 && cyc == pulse_at - 1) begin
        operando1 = '1;
        operando2 = '1;
        sinal     = 1'b1;
        start     = 1'b1;
      end
      if (pulse_at != 0 && cyc == pulse_at) start = 1'b0;
    end
    chk({nome, "_latency"}, 32'(lat), 32'd16);
    chk({nome, "_busy_cycles"}, 32'(nbusy), 32'd16);
    chk({nome, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard: every done pops one expected product.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        chk("busy_done_exclusive", {31'd0, busy}, 32'd0);
        chk("done_has_expected", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) chk("product", {mulH, mulL}, sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    vetor_t tab[8];
    int d0;
    logic nenhum_done;
    logic nenhum_busy;

    tab[0] = '{"u_3x5",        16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F};
    tab[1] = '{"u_ffff_ffff",  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001};
    tab[2] = '{"s_m1_m1",      16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0001};
    tab[3] = '{"s_min_min",    16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000};
    tab[4] = '{"s_min_1",      16'h8000, 16'h0001, 1'b1, 16'hFFFF, 16'h8000};
    tab[5] = '{"s_max_m1",     16'h7FFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'h8001};
    tab[6] = '{"u_min_min",    16'h8000, 16'h8000, 1'b0, 16'h4000, 16'h0000};
    tab[7] = '{"s_m1_1",       16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF};

    reset = 1'b1; start = 1'b0; sinal = 1'b0; operando1 = '0; operando2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_prod", {mulH, mulL}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d0 = done_cnt;
      launch(tab[i].a, tab[i].b, tab[i].s, {tab[i].exp_h, tab[i].exp_l});
      wait_done(tab[i].nome, 0);
      @(posedge clk); #1;
      chk({tab[i].nome, "_done_falls"}, {31'd0, done}, 32'd0);
      chk({tab[i].nome, "_hold"}, {mulH, mulL}, {tab[i].exp_h, tab[i].exp_l});
      #1;
      chk({tab[i].nome, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    end

    // Start pulsed mid-operation with new operands is ignored; start held in done launches next.
    @(negedge clk);
    d0 = done_cnt;
    launch(16'h1234, 16'h0010, 1'b0, 32'h0001_2340);
    wait_done("midop", 5);
    launch(16'h0007, 16'h0009, 1'b0, 32'd63);
    #1;
    chk("midop_one_done", 32'(done_cnt - d0), 32'd1);
    wait_done("b2b", 0);
    @(posedge clk); #1;
    chk("b2b_hold", {mulH, mulL}, 32'd63);

    // Asynchronous abort mid-operation.
    @(negedge clk);
    launch(16'h0002, 16'h0002, 1'b0, 32'd4);
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_prod_zero", {mulH, mulL}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    d0 = done_cnt;
    nenhum_done = 1'b1;
    nenhum_busy = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (done) nenhum_done = 1'b0;
      if (busy) nenhum_busy = 1'b0;
    end
    chk("abort_no_done", {31'd0, nenhum_done}, 32'd1);
    chk("abort_idle", {31'd0, nenhum_busy}, 32'd1);
    #1;
    chk("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);
    launch(16'h0002, 16'h0002, 1'b0, 32'd4);
    wait_done("after_abort", 0);
    chk("after_abort_mulL", {16'd0, mulL}, 32'd4);

    // Random operands, both modes, issued back-to-back.
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 1000; k++) begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = W'($urandom);
        b = W'($urandom);
        launch(a, b, m[0], ref_mul(a, b, m[0]));
        wait_done(m[0] ? "rnd_s" : "rnd_u", 0);
      end
    end
    @(posedge clk); #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
